// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//
// Parametrised two-read / one-write register bank for the processor datapath,
// with write-through forwarding, a read-enable that freezes the read outputs,
// and a pending-write scoreboard that flags reads of registers whose producer
// has not yet written back.
//
// Parameters:
//   DATA_W    bits per register
//   ADDR_W    address width, depth = 2**ADDR_W
//   ZERO_REG  1: register 0 reads 0, ignores writes and is never pending
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   rd_en               1: capture new read results; 0: read outputs hold
//   ra1, ra2            read addresses
//   rd1, rd2            registered read data
//   hazard1, hazard2    registered: address was pending when captured
//   we, wa, wd          write port (from writeback)
//   pend_set, pend_addr scoreboard claim (from decode)
//   pend_vec            scoreboard bits, bit i = register i pending
// -----------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        ra1,
    input  logic [ADDR_W-1:0]        ra2,
    output logic [DATA_W-1:0]        rd1,
    output logic [DATA_W-1:0]        rd2,
    output logic                     hazard1,
    output logic                     hazard2,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic [(1<<ADDR_W)-1:0]   pend_vec
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend_next;
    logic              wr_ok;

    // Writes to the hardwired zero register are dropped.
    assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

    // NOTE: the bank must read all-zero after reset, so every entry is a
    // resettable flop rather than an unreset RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking for all sequential state, so every flop
                // samples pre-edge values regardless of block ordering.
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    // Scoreboard: writeback clears, issue sets; a same-edge set wins because
    // the claim belongs to a newer producer.
    always_comb begin
        // NOTE: default first so no path leaves pend_next unassigned (no latch).
        pend_next = pend_vec;
        if (we)                pend_next[wa]        = 1'b0;
        if (pend_set)          pend_next[pend_addr] = 1'b1;
        if (ZERO_REG != 0)     pend_next[0]         = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_vec <= '0;
        else       pend_vec <= pend_next;
    end

    // Per-port read selection; hazard uses the pre-edge scoreboard so a
    // same-cycle claim by a younger instruction does not flag this read.
    logic [ADDR_W-1:0] ra_p      [2];
    logic [DATA_W-1:0] rd_next   [2];
    logic              hz_next   [2];

    assign ra_p[0] = ra1;
    assign ra_p[1] = ra2;

    for (genvar p = 0; p < 2; p++) begin : g_port
        always_comb begin
            rd_next[p] = mem[ra_p[p]];
            hz_next[p] = pend_vec[ra_p[p]];
            if ((ZERO_REG != 0) && (ra_p[p] == '0)) begin
                rd_next[p] = '0;
                hz_next[p] = 1'b0;
            end else if (we && (wa == ra_p[p])) begin
                rd_next[p] = wd;
                hz_next[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1     <= '0;
            rd2     <= '0;
            hazard1 <= 1'b0;
            hazard2 <= 1'b0;
        end else if (rd_en) begin
            rd1     <= rd_next[0];
            rd2     <= rd_next[1];
            hazard1 <= hz_next[0];
            hazard2 <= hz_next[1];
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// -----------------------------------------------------------------------------
// tb_reg_file_param
//
// Drives two instances of reg_file_param with identical stimulus, one with
// ZERO_REG=1 (index 0) and one with ZERO_REG=0 (index 1), and compares both
// against a behavioural model built from the register-file rules: reads are
// resolved from the pre-edge state, then the write and scoreboard update apply.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [4:0]  ra1, ra2, wa, pend_addr;
    logic        we, pend_set;
    logic [31:0] wd;

    logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;
    logic        hz1_z, hz2_z, hz1_n, hz2_n;
    logic [31:0] pv_z, pv_n;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_z (
        .clk(clk), .reset(reset), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_z), .rd2(rd2_z), .hazard1(hz1_z), .hazard2(hz2_z),
        .we(we), .wa(wa), .wd(wd), .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_vec(pv_z)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_n (
        .clk(clk), .reset(reset), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_n), .rd2(rd2_n), .hazard1(hz1_n), .hazard2(hz2_n),
        .we(we), .wa(wa), .wd(wd), .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_vec(pv_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];
    logic [31:0] e_rd1 [2], e_rd2 [2];
    logic        e_hz1 [2], e_hz2 [2];

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[z][i]  = '0;
                m_pend[z][i] = 1'b0;
            end
            e_rd1[z] = '0; e_rd2[z] = '0; e_hz1[z] = 1'b0; e_hz2[z] = 1'b0;
        end
    endtask

    task automatic model_read(input int z, input logic [4:0] ra,
                              output logic [31:0] d, output logic h);
        bit zr = (z == 0);
        if (zr && ra == 0) begin
            d = '0; h = 1'b0;
        end else if (we && wa == ra) begin
            d = wd; h = 1'b0;
        end else begin
            d = m_mem[z][ra]; h = m_pend[z][ra];
        end
    endtask

    // Called right at the rising edge, with inputs stable from the previous cycle.
    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            bit zr = (z == 0);
            logic [31:0] d1, d2;
            logic h1, h2;
            model_read(z, ra1, d1, h1);
            model_read(z, ra2, d2, h2);
            if (rd_en) begin
                e_rd1[z] = d1; e_rd2[z] = d2; e_hz1[z] = h1; e_hz2[z] = h2;
            end
            if (we && !(zr && wa == 0)) m_mem[z][wa] = wd;
            if (we) m_pend[z][wa] = 1'b0;
            if (pend_set && !(zr && pend_addr == 0)) m_pend[z][pend_addr] = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_pv(input int z);
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[z][i];
        return v;
    endfunction

    task automatic compare_all();
        check("z_rd1", rd1_z, e_rd1[0]);
        check("z_rd2", rd2_z, e_rd2[0]);
        check("z_hz1", 32'(hz1_z), 32'(e_hz1[0]));
        check("z_hz2", 32'(hz2_z), 32'(e_hz2[0]));
        check("z_pend", pv_z, model_pv(0));
        check("n_rd1", rd1_n, e_rd1[1]);
        check("n_rd2", rd2_n, e_rd2[1]);
        check("n_hz1", 32'(hz1_n), 32'(e_hz1[1]));
        check("n_hz2", 32'(hz2_n), 32'(e_hz2[1]));
        check("n_pend", pv_n, model_pv(1));
    endtask

    task automatic drive(input logic i_we, input logic [4:0] i_wa, input logic [31:0] i_wd,
                         input logic i_ps, input logic [4:0] i_pa,
                         input logic i_re, input logic [4:0] i_ra1, input logic [4:0] i_ra2);
        we = i_we; wa = i_wa; wd = i_wd; pend_set = i_ps; pend_addr = i_pa;
        rd_en = i_re; ra1 = i_ra1; ra2 = i_ra2;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        reset = 1'b0;
        compare_all();

        // Reset state read
        drive(0, 0, 0, 0, 0, 1, 3, 31); step();
        check("rst_rd1", rd1_z, 32'h0);
        check("rst_pv", pv_z, 32'h0);

        // Forwarding then stored read
        drive(1, 5, 32'hDEADBEEF, 0, 0, 1, 5, 0); step();
        check("fwd_rd1", rd1_z, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 1, 0, 5); step();
        check("mem_rd2", rd2_z, 32'hDEADBEEF);

        // Register 0 behaviour
        drive(1, 0, 32'h1234, 0, 0, 1, 1, 1); step();
        drive(0, 0, 0, 0, 0, 1, 0, 0); step();
        check("zero_rd1", rd1_z, 32'h0);
        check("nozero_rd1", rd1_n, 32'h1234);
        drive(0, 0, 0, 1, 0, 1, 0, 0); step();
        check("zero_pv0", 32'(pv_z[0]), 32'h0);
        check("nozero_pv0", 32'(pv_n[0]), 32'h1);

        // Scoreboard
        drive(0, 0, 0, 1, 7, 1, 7, 7); step();
        check("pend7_set", 32'(pv_z[7]), 32'h1);
        check("pend7_nohz", 32'(hz1_z), 32'h0);
        drive(0, 0, 0, 0, 0, 1, 7, 0); step();
        check("pend7_hz1", 32'(hz1_z), 32'h1);
        drive(1, 7, 32'h55, 0, 0, 1, 7, 0); step();
        check("wb7_rd1", rd1_z, 32'h55);
        check("wb7_hz1", 32'(hz1_z), 32'h0);
        check("wb7_pv", 32'(pv_z[7]), 32'h0);
        drive(1, 9, 32'h99, 1, 9, 1, 9, 9); step();
        check("set_wins", 32'(pv_z[9]), 32'h1);

        // Read hold
        drive(1, 2, 32'hAA, 0, 0, 1, 0, 0); step();
        drive(0, 0, 0, 0, 0, 1, 2, 2); step();
        check("hold_pre", rd1_z, 32'hAA);
        drive(1, 2, 32'hBB, 0, 0, 0, 2, 2); step();
        check("hold_wr", rd1_z, 32'hAA);
        drive(0, 0, 0, 0, 0, 0, 2, 2); step();
        check("hold_idle", rd1_z, 32'hAA);
        drive(0, 0, 0, 0, 0, 1, 2, 2); step();
        check("hold_rel", rd1_z, 32'hBB);

        // Asynchronous reset mid-cycle with a write pending
        drive(1, 4, 32'h77, 1, 12, 1, 2, 9); step();
        #2;
        drive(1, 4, 32'hCAFE, 1, 4, 1, 4, 4);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        compare_all();
        drive(0, 0, 0, 0, 0, 1, 4, 2); step();
        check("arst_rd1", rd1_z, 32'h0);
        check("arst_pv", pv_z, 32'h0);

        // Randomised traffic, addresses biased toward a small window for collisions
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a [4];
            for (int k = 0; k < 4; k++)
                a[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                   : 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), a[0], $urandom,
                  1'($urandom_range(0, 2) == 0), a[1],
                  1'($urandom_range(0, 4) != 0), a[2],
                  ($urandom_range(0, 4) == 0) ? a[2] : a[3]);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
